// File: rtl/if_prefetch_stage_pkg.sv
// Shared constants for the instruction-fetch prefetch stage: word sizes, bus
// direction, active-low enable levels and the bus-side FSM state encoding.
package if_prefetch_stage_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int REGION_TAG_W = 3;

  typedef enum logic [1:0] {
    IF_ST_IDLE   = 2'd0,
    IF_ST_REQ    = 2'd1,
    IF_ST_ACCESS = 2'd2
  } if_state_t;

  typedef struct packed {
    logic [WORD_ADDR_W-1:0] pc;
    logic [WORD_DATA_W-1:0] insn;
  } fetch_word_t;

endpackage

// File: rtl/if_prefetch_stage_queue.sv
// Prefetch FIFO holding {pc, insn} pairs between the fetch engine and ID.
// Clear has priority over push/pop; a push into a full queue is only taken
// when a pop frees the head slot in the same cycle.
module if_queue
  import if_prefetch_stage_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = WORD_ADDR_W,
  parameter int DATA_W = WORD_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ADDR_W-1:0]        push_pc,
  input  logic [DATA_W-1:0]        push_insn,
  output logic [ADDR_W-1:0]        head_pc,
  output logic [DATA_W-1:0]        head_insn,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] insn_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && !clear && ((count != FULL_COUNT) || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is only observed while count is nonzero.
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr]   <= push_pc;
      insn_mem[wr_ptr] <= push_insn;
    end
  end

  assign head_pc   = pc_mem[rd_ptr];
  assign head_insn = insn_mem[rd_ptr];

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with prefetch queue: sequential fetch from SPM
// (pipelined, one word per cycle) or the shared bus (req/grnt/as/rdy).
//
//  state        | meaning
//  IF_ST_IDLE   | no bus access; SPM fetches issue from here when credit allows
//  IF_ST_REQ    | bus_req_ asserted, waiting for bus_grnt_
//  IF_ST_ACCESS | bus_as_ on first cycle, waiting for bus_rdy_ (word may be dropped)
module if_prefetch_stage
  import if_prefetch_stage_pkg::*;
#(
  parameter int               DEPTH        = 4,
  parameter int               ADDR_W       = WORD_ADDR_W,
  parameter int               DATA_W       = WORD_DATA_W,
  parameter int               SPM_ADDR_W   = 12,
  parameter logic [2:0]       SPM_TAG      = 3'b011,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [ADDR_W-1:0]     new_pc,
  input  logic                  br_taken,
  input  logic [ADDR_W-1:0]     br_addr,
  input  logic [DATA_W-1:0]     spm_rd_data,
  output logic [SPM_ADDR_W-1:0] spm_addr,
  output logic                  spm_as_,
  output logic                  spm_rw,
  output logic [DATA_W-1:0]     spm_wr_data,
  input  logic [DATA_W-1:0]     bus_rd_data,
  input  logic                  bus_rdy_,
  input  logic                  bus_grnt_,
  output logic                  bus_req_,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic                  bus_as_,
  output logic                  bus_rw,
  output logic [DATA_W-1:0]     bus_wr_data,
  output logic [ADDR_W-1:0]     if_pc,
  output logic [DATA_W-1:0]     if_insn,
  output logic                  if_en_,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  if_state_t          state;
  if_state_t          state_nxt;
  logic [ADDR_W-1:0]  fpc;
  logic [ADDR_W-1:0]  spm_pc_q;
  logic [ADDR_W-1:0]  bus_pc_q;
  logic               spm_pend;
  logic               drop;
  logic               as_first;

  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               fpc_in_spm;
  logic [OCC_W-1:0]   occupancy;
  logic               credit;
  logic               spm_issue;
  logic               bus_start;
  logic               bus_done;

  logic               q_push;
  logic               q_pop;
  logic               q_empty;
  logic [CNT_W-1:0]   q_count;
  logic [ADDR_W-1:0]  push_pc;
  logic [DATA_W-1:0]  push_insn;
  logic [ADDR_W-1:0]  head_pc;
  logic [DATA_W-1:0]  head_insn;

  assign redirect    = flush | br_taken;
  assign redirect_pc = flush ? new_pc : br_addr;
  assign fpc_in_spm  = (fpc[ADDR_W-1 -: REGION_TAG_W] == SPM_TAG);

  // Words already requested count against the queue so nothing is ever fetched without a slot.
  assign occupancy = OCC_W'(q_count) + OCC_W'(spm_pend) + OCC_W'(state != IF_ST_IDLE);
  assign credit    = (occupancy < DEPTH_OCC);

  assign spm_issue = !reset && (state == IF_ST_IDLE) && fpc_in_spm && credit && !redirect;
  assign bus_start = (state == IF_ST_REQ) && (state_nxt == IF_ST_ACCESS);
  assign bus_done  = (state == IF_ST_ACCESS) && (bus_rdy_ == ENABLE_);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IF_ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IF_ST_IDLE: begin
        if (!redirect && !fpc_in_spm && credit) state_nxt = IF_ST_REQ;
      end
      IF_ST_REQ: begin
        if (redirect)                   state_nxt = IF_ST_IDLE;
        else if (bus_grnt_ == ENABLE_)  state_nxt = IF_ST_ACCESS;
      end
      IF_ST_ACCESS: begin
        if (bus_rdy_ == ENABLE_) state_nxt = IF_ST_IDLE;
      end
      default: state_nxt = IF_ST_IDLE;
    endcase
  end

  always_comb begin
    bus_req_ = DISABLE_;
    bus_as_  = DISABLE_;
    bus_addr = '0;
    case (state)
      IF_ST_REQ: bus_req_ = ENABLE_;
      IF_ST_ACCESS: begin
        bus_req_ = ENABLE_;
        bus_addr = bus_pc_q;
        if (as_first) bus_as_ = ENABLE_;
      end
      default: ;
    endcase
  end

  // A redirect during ACCESS lets the bus cycle finish but marks its word for discard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc      <= RESET_VECTOR;
      spm_pc_q <= '0;
      bus_pc_q <= '0;
      spm_pend <= 1'b0;
      drop     <= 1'b0;
      as_first <= 1'b0;
    end else begin
      spm_pend <= spm_issue;
      as_first <= bus_start;
      if (spm_issue) spm_pc_q <= fpc;
      if (bus_start) bus_pc_q <= fpc;

      if (redirect)
        fpc <= redirect_pc;
      else if (spm_issue || (bus_done && !drop))
        fpc <= fpc + 1'b1;

      if (bus_done)
        drop <= 1'b0;
      else if (redirect && (state == IF_ST_ACCESS))
        drop <= 1'b1;
    end
  end

  assign q_push    = !redirect && (spm_pend || (bus_done && !drop));
  assign q_pop     = !q_empty && !stall && !redirect;
  assign push_pc   = spm_pend ? spm_pc_q    : bus_pc_q;
  assign push_insn = spm_pend ? spm_rd_data : bus_rd_data;

  if_queue #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect),
    .push      (q_push),
    .pop       (q_pop),
    .push_pc   (push_pc),
    .push_insn (push_insn),
    .head_pc   (head_pc),
    .head_insn (head_insn),
    .count     (q_count),
    .empty     (q_empty)
  );

  assign spm_as_     = spm_issue ? ENABLE_ : DISABLE_;
  assign spm_addr    = spm_issue ? fpc[SPM_ADDR_W-1:0] : '0;
  assign spm_rw      = READ;
  assign spm_wr_data = '0;
  assign bus_rw      = READ;
  assign bus_wr_data = '0;

  assign if_en_  = q_empty ? DISABLE_ : ENABLE_;
  assign if_pc   = q_empty ? '0 : head_pc;
  assign if_insn = q_empty ? '0 : head_insn;
  assign busy    = q_empty && (state != IF_ST_IDLE);

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Self-checking bench for if_prefetch_stage: SPM/bus responders, a stream-level
// reference model (consecutive pcs from the last redirect target) and a scoreboard.
module tb_if_prefetch_stage;

  localparam int          DEPTH      = 4;
  localparam int          ADDR_W     = 30;
  localparam int          DATA_W     = 32;
  localparam int          SPM_ADDR_W = 12;
  localparam logic [29:0] RV         = 30'h1800_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [29:0] new_pc;
  logic        br_taken;
  logic [29:0] br_addr;
  logic [31:0] spm_rd_data;
  logic [11:0] spm_addr;
  logic        spm_as_;
  logic        spm_rw;
  logic [31:0] spm_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_;
  logic        bus_grnt_;
  logic        bus_req_;
  logic [29:0] bus_addr;
  logic        bus_as_;
  logic        bus_rw;
  logic [31:0] bus_wr_data;
  logic [29:0] if_pc;
  logic [31:0] if_insn;
  logic        if_en_;
  logic        busy;

  if_prefetch_stage #(
    .DEPTH        (DEPTH),
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .SPM_ADDR_W   (SPM_ADDR_W),
    .SPM_TAG      (3'b011),
    .RESET_VECTOR (RV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .br_taken    (br_taken),
    .br_addr     (br_addr),
    .spm_rd_data (spm_rd_data),
    .spm_addr    (spm_addr),
    .spm_as_     (spm_as_),
    .spm_rw      (spm_rw),
    .spm_wr_data (spm_wr_data),
    .bus_rd_data (bus_rd_data),
    .bus_rdy_    (bus_rdy_),
    .bus_grnt_   (bus_grnt_),
    .bus_req_    (bus_req_),
    .bus_addr    (bus_addr),
    .bus_as_     (bus_as_),
    .bus_rw      (bus_rw),
    .bus_wr_data (bus_wr_data),
    .if_pc       (if_pc),
    .if_insn     (if_insn),
    .if_en_      (if_en_),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] insn;
  } fetch_t;

  fetch_t exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     n_pops   = 0;
  int     g_lat    = 2;
  int     r_lat    = 3;
  bit     rand_lat = 1'b0;

  function automatic logic in_spm(input logic [29:0] pc);
    return pc[29:27] == 3'b011;
  endfunction

  function automatic logic [31:0] spm_word(input logic [11:0] a);
    return {20'hC0DE5, a};
  endfunction

  function automatic logic [31:0] bus_word(input logic [29:0] a);
    return {2'b10, a} ^ 32'h0055_AA00;
  endfunction

  function automatic logic [31:0] exp_word(input logic [29:0] pc);
    return in_spm(pc) ? spm_word(pc[11:0]) : bus_word(pc);
  endfunction

  function automatic logic [29:0] pick_target();
    case ($urandom_range(0, 5))
      0:       return RV | 30'($urandom_range(0, 4095));
      1:       return 30'h1FFF_FFFE;
      2:       return 30'h17FF_FFFE;
      3:       return 30'h3FFF_FFFE;
      default: return 30'($urandom_range(0, 32'h3FFF_FFFF));
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The delivered stream after any redirect is the target and its successors, modulo 2^30.
  task automatic restart(input logic [29:0] start);
    logic [29:0] p;
    exp_q.delete();
    p = start;
    for (int i = 0; i < 200; i++) begin
      exp_q.push_back({p, exp_word(p)});
      p = p + 30'd1;
    end
  endtask

  task automatic do_redirect(input logic f, input logic [29:0] fpc_t,
                             input logic b, input logic [29:0] bpc);
    @(posedge clk); #1;
    flush    = f;
    new_pc   = fpc_t;
    br_taken = b;
    br_addr  = bpc;
    restart(f ? fpc_t : bpc);
    @(posedge clk); #1;
    flush    = 1'b0;
    br_taken = 1'b0;
  endtask

  task automatic wait_bus_as(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (bus_as_ && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({name, "_as_seen"}, 64'(bus_as_ == 1'b0), 64'd1);
  endtask

  // SPM responder: data is valid the cycle after the strobe.
  initial begin
    logic        hit;
    logic [11:0] a;
    spm_rd_data = '0;
    forever begin
      @(negedge clk);
      hit = !spm_as_;
      a   = spm_addr;
      @(posedge clk); #1;
      spm_rd_data = hit ? spm_word(a) : 32'hDEAD_BEEF;
    end
  end

  // Bus responder: grant some cycles after request, ready some cycles after the address strobe.
  initial begin
    logic        s_req;
    logic        s_as;
    logic [29:0] s_addr;
    logic [29:0] a;
    logic        pending;
    int          gcnt;
    int          rcnt;
    bus_grnt_   = 1'b1;
    bus_rdy_    = 1'b1;
    bus_rd_data = '0;
    pending     = 1'b0;
    gcnt        = 0;
    rcnt        = 0;
    a           = '0;
    forever begin
      @(negedge clk);
      s_req  = bus_req_;
      s_as   = bus_as_;
      s_addr = bus_addr;
      @(posedge clk); #1;
      bus_rdy_    = 1'b1;
      bus_rd_data = 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
      if (reset || s_req) begin
        bus_grnt_ = 1'b1;
        gcnt      = 0;
        pending   = 1'b0;
        if (rand_lat) g_lat = $urandom_range(1, 3);
      end else begin
        if (bus_grnt_) begin
          gcnt++;
          if (gcnt >= g_lat) bus_grnt_ = 1'b0;
        end
        if (!s_as) begin
          pending = 1'b1;
          rcnt    = 0;
          a       = s_addr;
          if (rand_lat) r_lat = $urandom_range(1, 4);
        end
        if (pending) begin
          rcnt++;
          if (rcnt >= r_lat) begin
            bus_rdy_    = 1'b0;
            bus_rd_data = bus_word(a);
            pending     = 1'b0;
          end
        end
      end
    end
  end

  // Scoreboard monitor: every head consumed by ID is compared with the model stream.
  initial begin
    fetch_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("busy", 64'(busy), 64'(if_en_ && !bus_req_));
        if (!if_en_ && !stall && !flush && !br_taken) begin
          check("exp_available", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("if_pc", 64'(if_pc), 64'(e.pc));
            check("if_insn", 64'(if_insn), 64'(e.insn));
            n_pops++;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL global_timeout: got running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    int  strobes;
    int  n;
    int  seg;
    int  k;
    bit  busy_seen;

    reset    = 1'b1;
    stall    = 1'b0;
    flush    = 1'b0;
    br_taken = 1'b0;
    new_pc   = '0;
    br_addr  = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_if_en_",     64'(if_en_),      64'd1);
    check("rst_if_pc",      64'(if_pc),       64'd0);
    check("rst_if_insn",    64'(if_insn),     64'd0);
    check("rst_spm_as_",    64'(spm_as_),     64'd1);
    check("rst_spm_addr",   64'(spm_addr),    64'd0);
    check("rst_bus_req_",   64'(bus_req_),    64'd1);
    check("rst_bus_as_",    64'(bus_as_),     64'd1);
    check("rst_bus_addr",   64'(bus_addr),    64'd0);
    check("rst_busy",       64'(busy),        64'd0);
    check("rst_spm_rw",     64'(spm_rw),      64'd1);
    check("rst_bus_rw",     64'(bus_rw),      64'd1);
    check("rst_spm_wr",     64'(spm_wr_data), 64'd0);
    check("rst_bus_wr",     64'(bus_wr_data), 64'd0);

    // SPM start-up with ID stalled: four strobes fill the queue, then fetch stops.
    restart(RV);
    @(posedge clk); #1;
    reset   = 1'b0;
    stall   = 1'b1;
    strobes = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      strobes += (spm_as_ == 1'b0) ? 1 : 0;
      if (c == 2) check("if_en_cycle1", 64'(if_en_), 64'd1);
      if (c == 3) check("if_en_cycle2", 64'(if_en_), 64'd0);
    end
    check("stall_strobes",   64'(strobes), 64'(DEPTH));
    check("stall_spm_as_",   64'(spm_as_), 64'd1);
    check("stall_head_pc",   64'(if_pc),   64'(RV));
    check("stall_head_insn", 64'(if_insn), 64'(spm_word(RV[11:0])));
    @(posedge clk); #1;
    stall = 1'b0;
    repeat (12) @(posedge clk);

    // Bus fetch with grant after 2 and ready after 3 cycles.
    g_lat = 2;
    r_lat = 3;
    do_redirect(1'b1, 30'h100, 1'b0, 30'h0);
    busy_seen = 1'b0;
    n = 0;
    @(negedge clk);
    while (if_en_ && n < 40) begin
      if (busy) busy_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    check("bus_first_valid", 64'(if_en_), 64'd0);
    check("bus_busy_seen",   64'(busy_seen), 64'd1);
    check("bus_first_pc",    64'(if_pc), 64'h100);
    repeat (15) @(posedge clk);

    // Branch during ACCESS: the in-flight word is discarded.
    wait_bus_as("br_access");
    do_redirect(1'b0, 30'h0, 1'b1, 30'h96);
    repeat (25) @(posedge clk);

    // Flush and branch together: flush target wins.
    do_redirect(1'b1, 30'h97, 1'b1, 30'h96);
    n = 0;
    @(negedge clk);
    while (if_en_ && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("flush_wins_pc", 64'(if_pc), 64'h97);
    repeat (10) @(posedge clk);

    // Reset in the middle of a bus access.
    wait_bus_as("rst_access");
    #2;
    reset = 1'b1;
    restart(RV);
    #1;
    check("midrst_bus_as_",  64'(bus_as_),  64'd1);
    check("midrst_bus_req_", 64'(bus_req_), 64'd1);
    check("midrst_if_en_",   64'(if_en_),   64'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0;
    @(negedge clk);
    while (if_en_ && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("midrst_refetch_pc", 64'(if_pc), 64'(RV));
    repeat (10) @(posedge clk);

    // Randomised stall, redirect targets and bus latencies.
    rand_lat = 1'b1;
    seg = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk); #1;
      stall = ($urandom_range(0, 3) == 0);
      seg++;
      if (seg > 120 || $urandom_range(0, 39) == 0) begin
        seg      = 0;
        k        = $urandom_range(0, 2);
        flush    = (k != 1);
        br_taken = (k != 0);
        new_pc   = pick_target();
        br_addr  = pick_target();
        restart(flush ? new_pc : br_addr);
      end else begin
        flush    = 1'b0;
        br_taken = 1'b0;
      end
    end
    @(posedge clk); #1;
    flush    = 1'b0;
    br_taken = 1'b0;
    stall    = 1'b0;
    repeat (5) @(posedge clk);

    check("progress", 64'(n_pops >= 300), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
